// File: rtl/qracc_csr_slave.sv
// QRAcc control-interface responder: shadow config registers, atomic commit to cfg_o, start pulse.
// Optional QRACC_CSR_READBACK_EN makes config registers 0x08-0x28 readable.
package qracc_csr_pkg;
    typedef struct packed {
        logic [3:0]  n_input_bits_cfg;
        logic [3:0]  n_output_bits_cfg;
        logic        binary_cfg;
        logic [2:0]  adc_ref_range_shifts;
        logic [3:0]  filter_size_y;
        logic [3:0]  filter_size_x;
        logic [31:0] input_fmap_size;
        logic [31:0] output_fmap_size;
        logic [31:0] input_fmap_dimx;
        logic [31:0] input_fmap_dimy;
        logic [31:0] output_fmap_dimx;
        logic [31:0] output_fmap_dimy;
        logic [9:0]  num_input_channels;
        logic [9:0]  num_output_channels;
        logic [9:0]  mapped_matrix_offset_x;
        logic [9:0]  mapped_matrix_offset_y;
    } qracc_config_t;
endpackage

module qracc_csr_slave
    import qracc_csr_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE    = 32'h0000_0000,
    parameter int          RESET_N_BITS = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   ctrl_data_i,
    input  logic [31:0]   ctrl_addr_i,
    input  logic          ctrl_wen_i,
    input  logic          ctrl_valid_i,
    output logic          ctrl_ready_o,
    output logic [31:0]   ctrl_read_data_o,
    input  logic          busy_i,
    output qracc_config_t cfg_o,
    output logic          start_o,
    output logic          commit_pending_o
);

    typedef enum logic {IDLE, RESP} state_t;

    state_t        state_q, state_d;
    qracc_config_t shadow;
    logic          err;
    logic          pend_start;
    logic          accept;
    logic          legal;
    logic [5:0]    idx;
    logic [31:0]   rd_word;
    logic          unused_addr_lsb;

    assign unused_addr_lsb = &{1'b0, ctrl_addr_i[1:0]};

    function automatic qracc_config_t cfg_reset();
        qracc_config_t c;
        c = '0;
        c.n_input_bits_cfg  = 4'(RESET_N_BITS);
        c.n_output_bits_cfg = 4'(RESET_N_BITS);
        c.filter_size_x     = 4'd1;
        c.filter_size_y     = 4'd1;
        return c;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        ctrl_ready_o = 1'b0;
        case (state_q)
            IDLE: begin
                ctrl_ready_o = 1'b1;
                if (ctrl_valid_i) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign accept = ctrl_valid_i && ctrl_ready_o;
    assign idx    = ctrl_addr_i[7:2];
    assign legal  = (ctrl_addr_i[31:8] == ADDR_BASE[31:8]) && (idx <= 6'd10);

    always_comb begin
        rd_word = '0;
        case (idx)
            6'd1: rd_word = {29'd0, err, commit_pending_o, busy_i};
`ifdef QRACC_CSR_READBACK_EN
            6'd2: rd_word = {12'd0, shadow.filter_size_x, shadow.filter_size_y,
                             shadow.adc_ref_range_shifts, shadow.binary_cfg,
                             shadow.n_output_bits_cfg, shadow.n_input_bits_cfg};
            6'd3:  rd_word = shadow.input_fmap_size;
            6'd4:  rd_word = shadow.output_fmap_size;
            6'd5:  rd_word = shadow.input_fmap_dimx;
            6'd6:  rd_word = shadow.input_fmap_dimy;
            6'd7:  rd_word = shadow.output_fmap_dimx;
            6'd8:  rd_word = shadow.output_fmap_dimy;
            6'd9:  rd_word = {6'd0, shadow.num_output_channels, 6'd0, shadow.num_input_channels};
            6'd10: rd_word = {6'd0, shadow.mapped_matrix_offset_y, 6'd0, shadow.mapped_matrix_offset_x};
`endif
            default: rd_word = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_read_data_o <= '0;
            shadow           <= cfg_reset();
            cfg_o            <= cfg_reset();
            err              <= 1'b0;
            commit_pending_o <= 1'b0;
            pend_start       <= 1'b0;
            start_o          <= 1'b0;
        end else begin
            start_o <= 1'b0;

            // Deferred commit drains the instant the accelerator goes idle.
            if (commit_pending_o && !busy_i) begin
                cfg_o            <= shadow;
                commit_pending_o <= 1'b0;
                start_o          <= pend_start;
                pend_start       <= 1'b0;
            end

            if (accept && !legal) err <= 1'b1;

            if (accept && !ctrl_wen_i) ctrl_read_data_o <= legal ? rd_word : 32'd0;

            if (accept && ctrl_wen_i && legal) begin
                case (idx)
                    6'd0: begin
                        if (ctrl_data_i[0]) begin
                            if (!commit_pending_o) begin
                                if (!busy_i) begin
                                    cfg_o   <= shadow;
                                    start_o <= ctrl_data_i[1];
                                end else begin
                                    commit_pending_o <= 1'b1;
                                    pend_start       <= ctrl_data_i[1];
                                end
                            end
                        end else if (ctrl_data_i[1]) begin
                            if (!busy_i && !commit_pending_o) start_o <= 1'b1;
                            else                              err     <= 1'b1;
                        end
                    end
                    6'd1: if (ctrl_data_i[2]) err <= 1'b0;
                    6'd2: begin
                        shadow.n_input_bits_cfg     <= ctrl_data_i[3:0];
                        shadow.n_output_bits_cfg    <= ctrl_data_i[7:4];
                        shadow.binary_cfg           <= ctrl_data_i[8];
                        shadow.adc_ref_range_shifts <= ctrl_data_i[11:9];
                        shadow.filter_size_y        <= ctrl_data_i[15:12];
                        shadow.filter_size_x        <= ctrl_data_i[19:16];
                    end
                    6'd3: shadow.input_fmap_size  <= ctrl_data_i;
                    6'd4: shadow.output_fmap_size <= ctrl_data_i;
                    6'd5: shadow.input_fmap_dimx  <= ctrl_data_i;
                    6'd6: shadow.input_fmap_dimy  <= ctrl_data_i;
                    6'd7: shadow.output_fmap_dimx <= ctrl_data_i;
                    6'd8: shadow.output_fmap_dimy <= ctrl_data_i;
                    6'd9: begin
                        shadow.num_input_channels  <= ctrl_data_i[9:0];
                        shadow.num_output_channels <= ctrl_data_i[25:16];
                    end
                    6'd10: begin
                        shadow.mapped_matrix_offset_x <= ctrl_data_i[9:0];
                        shadow.mapped_matrix_offset_y <= ctrl_data_i[25:16];
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/qracc_csr_slave.md
Name: qracc_csr_slave

Overview:
- Responder (slave) end of the QRAcc generic 32-bit control interface.
- Decodes word-addressed register reads and writes into a shadow copy of qracc_config_t.
- On a commit, atomically transfers the shadow copy to the active per-layer config consumed by the accelerator controller, and issues a start pulse.
- Sits between the host/bus master and the QRAcc controller.

Parameters:
- ADDR_BASE, 32'h0000_0000, register window base; accesses with addr[31:8] != ADDR_BASE[31:8] are out-of-window.
- RESET_N_BITS, 4, reset value of n_input_bits_cfg and n_output_bits_cfg.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ctrl_data_i  in  32  write data
- ctrl_addr_i  in  32  byte address; addr[7:2] selects register, addr[1:0] ignored
- ctrl_wen_i  in  1  1=write, 0=read
- ctrl_valid_i  in  1  request valid
- ctrl_ready_o  out  1  request accepted when valid&&ready
- ctrl_read_data_o  out  32  read response
- busy_i  in  1  accelerator busy; config must not change while high
- cfg_o  out  qracc_config_t (252)  active config
- start_o  out  1  one-cycle start pulse
- commit_pending_o  out  1  commit requested but not yet applied

Behaviour:
- One clock domain; reset is synchronous and active-high. Ports are clk and rst.
- Reset values:
  - ctrl_ready_o=1, ctrl_read_data_o=0, start_o=0, commit_pending_o=0, error flag=0.
  - Shadow and cfg_o all zero, except n_input_bits_cfg=n_output_bits_cfg=RESET_N_BITS and filter_size_x=filter_size_y=1.
- FSM has two states, IDLE and RESP:
  - IDLE: ready=1. On valid&&ready, perform the access and go to RESP.
  - RESP: ready=0 for exactly one cycle, then return to IDLE. Maximum rate is one transaction per 2 cycles.
- Read data is registered. It is valid from the RESP cycle onward and held until the next accepted read. Writes do not change ctrl_read_data_o.
- Register map (byte offsets):
  - 0x00 CTRL (W): bit0 COMMIT, bit1 START. Self-clearing; reads as 0.
  - 0x04 STATUS: bit0 busy_i, bit1 commit_pending, bit2 ERR (sticky). Writing 1 to bit2 clears ERR; other bits are RO.
  - 0x08 MODE: [3:0] n_input_bits, [7:4] n_output_bits, [8] binary_cfg, [11:9] adc_ref_range_shifts, [15:12] filter_size_y, [19:16] filter_size_x.
  - 0x0C input_fmap_size; 0x10 output_fmap_size; 0x14 input_fmap_dimx; 0x18 input_fmap_dimy; 0x1C output_fmap_dimx; 0x20 output_fmap_dimy.
  - 0x24 [9:0] num_input_channels, [25:16] num_output_channels.
  - 0x28 [9:0] mapped_matrix_offset_x, [25:16] mapped_matrix_offset_y.
  - Unused bits are write-ignored and read as 0.
- Illegal access (out-of-window address or unmapped offset):
  - Read returns 0; write has no effect.
  - ERR=1. The request still completes through RESP.
- COMMIT:
  - If busy_i=0 in the accept cycle, cfg_o <= shadow at that edge (visible in RESP).
  - Otherwise commit_pending=1. In each later cycle with pending && !busy_i, cfg_o <= the current shadow and pending is cleared.
  - Shadow writes made while pending are included in the eventual apply.
  - A repeated COMMIT while pending is a no-op.
- START:
  - With COMMIT in the same write: start_o pulses in the cycle cfg_o first shows the new value, including the deferred case.
  - START alone with busy_i=0 and no commit pending: start_o pulses in RESP.
  - START alone with busy_i=1 or a commit pending: no pulse, ERR=1.
- cfg_o never changes while busy_i=1.
- rst mid-transaction: FSM returns to IDLE, pending and start are dropped, and all registers return to reset values next cycle.

Optional Feature:
- QRACC_CSR_READBACK_EN
  - Defined: config registers 0x08–0x28 read back the shadow values.
  - Undefined: those offsets read as 0 (write-only) without setting ERR. STATUS remains readable.
  - Write behaviour is identical in both cases.

Test Plan:
- Reset, then read 0x08 -> ready high in cycle 0 after reset; read_data = 0x0001_1044 (with READBACK_EN).
- Write 0x0C=0x0000_C400, then CTRL=0x1 with busy_i=0 -> cfg_o.input_fmap_size=0xC400 in RESP cycle; ready low exactly one cycle.
- busy_i=1; CTRL=0x3 -> commit_pending_o=1, cfg_o unchanged. Write 0x24=0x0040_0020, drop busy_i -> same cycle cfg_o channels in=32/out=64, start_o one-cycle pulse, pending cleared.
- Read offset 0x3C and address 0x0000_0108 -> read_data=0, STATUS bit2=1. Write STATUS=0x4 -> ERR clears.
- START alone with busy_i=1 -> no start_o, ERR=1.
- Assert rst during a deferred commit -> pending=0, cfg_o back to reset values, no start_o after busy_i falls.
